// File: rtl/shift_issue_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_issue_queue_if                                         |
// | Description : Command, shifter and result signal bundle for                |
// |               shift_issue_queue. The slave modport is the queue itself;    |
// |               the master modport is the environment around it (command     |
// |               producer, barrel shifter and result consumer).               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface shift_issue_queue_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3,
  parameter int DEPTH   = 4
);
  // command side
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [SHAMT_W-1:0]         in_n;
  logic                       in_lr;
  // combinational shifter side
  logic [DATA_W-1:0]          sh_in;
  logic [SHAMT_W-1:0]         sh_n;
  logic                       sh_lr;
  logic [DATA_W-1:0]          sh_out;
  // result side
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [SHAMT_W-1:0]         out_n;
  logic                       out_lr;
  // occupancy
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  in_valid, in_data, in_n, in_lr, sh_out, out_ready,
    output in_ready, sh_in, sh_n, sh_lr, out_valid, out_data, out_n, out_lr, count
  );

  modport master (
    output in_valid, in_data, in_n, in_lr, sh_out, out_ready,
    input  in_ready, sh_in, sh_n, sh_lr, out_valid, out_data, out_n, out_lr, count
  );
endinterface
`default_nettype wire

// File: rtl/shift_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_issue_queue                                            |
// | Description : Issue stage for an 8-bit combinational barrel shifter.       |
// |               Buffers {data, n, lr} commands in a FIFO, presents the head  |
// |               to the shifter and registers the shifter result behind a     |
// |               valid/ready handshake.                                       |
// |               Optional macro SHIFT_ISSUE_BYPASS_EN: a command arriving     |
// |               while the FIFO is empty and the output stage can load goes   |
// |               straight to the shifter (1-cycle latency instead of 2).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_issue_queue #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3,
  parameter int DEPTH   = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  shift_issue_queue_if.slave  bus
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  // FIFO storage and pointers
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic [SHAMT_W-1:0] r_mem_n    [DEPTH];
  logic               r_mem_lr   [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_in_ready;

  // output stage
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [SHAMT_W-1:0] r_out_n;
  logic               r_out_lr;

  logic               w_empty;
  logic               w_can_load;
  logic               w_push;
  logic               w_bypass;
  logic               w_fifo_push;
  logic               w_pop;
  logic               w_load;
  logic [c_PTR_W-1:0] w_head_idx;
  logic [c_CNT_W-1:0] w_count_next;
  logic [DATA_W-1:0]  w_sh_in;
  logic [SHAMT_W-1:0] w_sh_n;
  logic               w_sh_lr;

  assign w_empty    = (r_count == '0);
  assign w_can_load = ~r_out_valid | bus.out_ready;
  assign w_push     = bus.in_valid & r_in_ready;

`ifdef SHIFT_ISSUE_BYPASS_EN
  assign w_bypass   = w_empty & w_can_load & w_push;
`else
  assign w_bypass   = 1'b0;
`endif

  assign w_fifo_push = w_push & ~w_bypass;
  assign w_pop       = ~w_empty & w_can_load;
  assign w_load      = w_pop | w_bypass;

  // When empty, keep showing the most recently popped entry so the shifter
  // never sees X (entries are cleared on reset, so this is 0 after reset).
  assign w_head_idx  = w_empty ? (r_rd_ptr - 1'b1) : r_rd_ptr;

  assign w_count_next = r_count + c_CNT_W'(w_fifo_push) - c_CNT_W'(w_pop);

  // Shifter operand select: FIFO head, or the incoming command on bypass
  always_comb begin
    w_sh_in = r_mem_data[w_head_idx];
    w_sh_n  = r_mem_n[w_head_idx];
    w_sh_lr = r_mem_lr[w_head_idx];
    if (w_bypass) begin
      w_sh_in = bus.in_data;
      w_sh_n  = bus.in_n;
      w_sh_lr = bus.in_lr;
    end
  end

  // FIFO entries, pointers, occupancy and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_n[i]    <= '0;
        r_mem_lr[i]   <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_fifo_push) begin
        r_mem_data[r_wr_ptr] <= bus.in_data;
        r_mem_n[r_wr_ptr]    <= bus.in_n;
        r_mem_lr[r_wr_ptr]   <= bus.in_lr;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      // Registered so a pop in the same cycle cannot reopen a full queue
      r_in_ready <= (w_count_next != c_FULL_CNT);
    end
  end

  // Output register: capture shifter result on load, drop valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_n     <= '0;
      r_out_lr    <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.sh_out;
      r_out_n     <= w_sh_n;
      r_out_lr    <= w_sh_lr;
    end else if (r_out_valid & bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.sh_in     = w_sh_in;
  assign bus.sh_n      = w_sh_n;
  assign bus.sh_lr     = w_sh_lr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_n     = r_out_n;
  assign bus.out_lr    = r_out_lr;
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_issue_queue                                         |
// | Description : Scoreboard bench for shift_issue_queue with a behavioural    |
// |               barrel shifter (lr=1 left, lr=0 right, logical) closing the  |
// |               sh_* -> sh_out loop. Honours SHIFT_ISSUE_BYPASS_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_issue_queue;

  localparam int c_DATA_W  = 8;
  localparam int c_SHAMT_W = 3;
  localparam int c_DEPTH   = 4;
`ifdef SHIFT_ISSUE_BYPASS_EN
  localparam logic c_BYP = 1'b1;
`else
  localparam logic c_BYP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] n;
    logic       lr;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb_q[$];

  shift_issue_queue_if #(.DATA_W(c_DATA_W), .SHAMT_W(c_SHAMT_W), .DEPTH(c_DEPTH)) bus ();

  shift_issue_queue #(.DATA_W(c_DATA_W), .SHAMT_W(c_SHAMT_W), .DEPTH(c_DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_shift(input logic [7:0] d, input logic [2:0] n, input logic lr);
    return lr ? (d << n) : (d >> n);
  endfunction

  // behavioural barrel shifter
  always_comb bus.sh_out = f_shift(bus.sh_in, bus.sh_n, bus.sh_lr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: handshakes observed mid-cycle, take effect at next edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_n",    32'(bus.out_n),    32'(e.n));
          chk("out_lr",   32'(bus.out_lr),   32'(e.lr));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        res_t e;
        e.d  = f_shift(bus.in_data, bus.in_n, bus.in_lr);
        e.n  = bus.in_n;
        e.lr = bus.in_lr;
        sb_q.push_back(e);
      end
    end
  end

  // Offer one command until accepted; returns #1 after the accepting edge
  task automatic send(input logic [7:0] d, input logic [2:0] n, input logic lr);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_n     = n;
    bus.in_lr    = lr;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Let all expected results out; returns #1 after an edge
  task automatic drain();
    int w;
    w = 0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    while ((sb_q.size() != 0 || bus.out_valid) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    res_t hold;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_n      = '0;
    bus.in_lr     = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_n",     32'(bus.out_n),     32'd0);
    chk("rst_out_lr",    32'(bus.out_lr),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1. reset mid-stream
    send(8'h81, 3'd1, 1'b0);
    send(8'h3C, 3'd2, 1'b1);
    send(8'h55, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_out_valid_pre", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_count",     32'(bus.count),     32'd0);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_out_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_count_rel", 32'(bus.count),   32'd0);

    // 2. single command, latency
    bus.out_ready = 1'b1;
    send(8'hF0, 3'd0, 1'b1);
    chk("lat_t", 32'(bus.out_valid), 32'(c_BYP));
    if (!c_BYP) begin
      @(posedge clk);
      #1;
    end
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data",  32'(bus.out_data),  32'hF0);
    chk("lat_n",     32'(bus.out_n),     32'd0);
    chk("lat_lr",    32'(bus.out_lr),    32'd1);
    drain();

    // 3. ordering
    send(8'hB3, 3'd3, 1'b0);
    send(8'hB3, 3'd2, 1'b1);
    send(8'h0F, 3'd1, 1'b0);
    send(8'h0F, 3'd1, 1'b1);
    drain();

    // 4. backpressure to full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h11 * (i + 1)), 3'(i), 1'(i & 1));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.in_n     = 3'd7;
    bus.in_lr    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready",  32'(bus.in_ready),  32'd0);
      chk("full_count",     32'(bus.count),     32'd4);
      chk("full_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("full_sb_size", 32'(sb_q.size()), 32'd5);
    drain();

    // 5. simultaneous push and pop at count 2
    bus.out_ready = 1'b0;
    send(8'hA5, 3'd1, 1'b1);
    send(8'h5A, 3'd2, 1'b0);
    send(8'hC3, 3'd3, 1'b1);
    chk("pp_count_start", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(255)), 3'($urandom_range(7)), 1'($urandom_range(1)));
      chk("pp_count", 32'(bus.count), 32'd2);
    end
    drain();

    // 6. stall hold while pushing
    bus.out_ready = 1'b0;
    send(8'h96, 3'd4, 1'b0);
    if (!c_BYP) begin
      @(posedge clk);
      #1;
    end
    hold = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i < 3) send(8'(8'h21 + i), 3'(i + 1), 1'(i & 1));
      else begin
        @(posedge clk);
        #1;
      end
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data",  32'(bus.out_data),  32'(hold.d));
      chk("stall_n",     32'(bus.out_n),     32'(hold.n));
      chk("stall_lr",    32'(bus.out_lr),    32'(hold.lr));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
